// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: pipeline-side status in, stall/flush controls out.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 32
);
  logic                           id_valid;
  logic [NUM_SRC*REG_IDX_W-1:0]   id_src_idx;
  logic [NUM_SRC-1:0]             id_src_used;
  logic                           ex_valid;
  logic [REG_IDX_W-1:0]           ex_reg_wr_idx;
  logic                           ex_mem_read_en;
  logic                           ex_mc_start;
  logic                           mc_done;
  logic                           redirect_req;
  logic                           mem_busy;
  logic                           fe_enable;
  logic                           id_ex_enable;
  logic                           if_id_clear;
  logic                           id_ex_clear;
  logic                           ex_mem_clear;
  logic [CNT_W-1:0]               stall_cycles;

  modport master (
    output id_valid, id_src_idx, id_src_used, ex_valid, ex_reg_wr_idx,
           ex_mem_read_en, ex_mc_start, mc_done, redirect_req, mem_busy,
    input  fe_enable, id_ex_enable, if_id_clear, id_ex_clear, ex_mem_clear,
           stall_cycles
  );

  modport slave (
    input  id_valid, id_src_idx, id_src_used, ex_valid, ex_reg_wr_idx,
           ex_mem_read_en, ex_mc_start, mc_done, redirect_req, mem_busy,
    output fe_enable, id_ex_enable, if_id_clear, id_ex_clear, ex_mem_clear,
           stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stalls, multi-cycle op waits,
// redirect flushes and memory wait-state freeze, plus a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned REG_IDX_W   = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MC_WAIT} state_t;

  localparam logic [1:0] LD_RELOAD = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_DEPTH - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ld_cnt, w_ld_cnt_nxt;
  logic [1:0]       r_fl_cnt, w_fl_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_match, w_load_use;
  logic             w_fe, w_idex_en, w_ifid_clr, w_idex_clr, w_exmem_clr;

  always_comb begin
    w_match = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] &&
          bus.id_src_idx[i*REG_IDX_W +: REG_IDX_W] == bus.ex_reg_wr_idx)
        w_match = 1'b1;
    end
  end

  // ID content is being squashed while the flush counter runs, so no hazard
  assign w_load_use = bus.id_valid && bus.ex_valid && bus.ex_mem_read_en &&
                      (bus.ex_reg_wr_idx != '0) && w_match && (r_fl_cnt == '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_cnt_nxt = r_ld_cnt;
    w_fl_cnt_nxt = (r_fl_cnt != '0) ? r_fl_cnt - 2'd1 : '0;
    w_fe         = 1'b1;
    w_idex_en    = 1'b1;
    w_ifid_clr   = (r_fl_cnt != '0);
    w_idex_clr   = 1'b0;
    w_exmem_clr  = 1'b0;
    if (rst) begin
      w_ifid_clr = 1'b0;
    end else if (bus.mem_busy) begin
      w_fe         = 1'b0;
      w_idex_en    = 1'b0;
      w_ifid_clr   = 1'b0;
      w_fl_cnt_nxt = r_fl_cnt;
    end else begin
      unique case (r_state)
        MC_WAIT: begin
          if (bus.mc_done) begin
            w_state_nxt = RUN;
          end else begin
            w_fe        = 1'b0;
            w_idex_en   = 1'b0;
            w_exmem_clr = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (bus.redirect_req) begin
            w_ifid_clr   = 1'b1;
            w_idex_clr   = 1'b1;
            w_fl_cnt_nxt = FL_RELOAD;
            w_ld_cnt_nxt = '0;
            w_state_nxt  = RUN;
          end else begin
            w_fe         = 1'b0;
            w_idex_clr   = 1'b1;
            w_ld_cnt_nxt = r_ld_cnt - 2'd1;
            if (r_ld_cnt <= 2'd1) w_state_nxt = RUN;
          end
        end
        default: begin
          if (bus.redirect_req) begin
            w_ifid_clr   = 1'b1;
            w_idex_clr   = 1'b1;
            w_fl_cnt_nxt = FL_RELOAD;
          end else if (w_load_use) begin
            w_fe       = 1'b0;
            w_idex_clr = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt  = LOAD_STALL;
              w_ld_cnt_nxt = LD_RELOAD;
            end
          end else if (bus.ex_mc_start && !bus.mc_done) begin
            w_state_nxt = MC_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_ld_cnt    <= '0;
      r_fl_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_cnt <= w_ld_cnt_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
      if (!w_fe && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.fe_enable    = w_fe;
  assign bus.id_ex_enable = w_idex_en;
  assign bus.if_id_clear  = w_ifid_clr;
  assign bus.id_ex_clear  = w_idex_clr;
  assign bus.ex_mem_clear = w_exmem_clr;
  assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=2, FLUSH_DEPTH=3, 8-bit stall counter)
// with a scoreboard queue of expected control outputs and stall counts.
module tb_hazard_ctrl;
  localparam int unsigned NS = 2, RW = 5, LL = 2, FD = 3, CW = 8;

  // expected output vector order: {fe, id_ex_en, if_id_clr, id_ex_clr, ex_mem_clr}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] LDS  = 5'b01010;
  localparam logic [4:0] MCW  = 5'b00001;
  localparam logic [4:0] BUSY = 5'b00000;
  localparam logic [4:0] RDR  = 5'b11110;
  localparam logic [4:0] FLS  = 5'b11100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.NUM_SRC(NS), .REG_IDX_W(RW), .CNT_W(CW)) bus();

  hazard_ctrl #(
    .NUM_SRC(NS), .REG_IDX_W(RW), .LOAD_LAT(LL), .FLUSH_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string         tag;
    logic [4:0]    outs;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] m_stall = '0;

  task automatic idle();
    bus.id_valid       = 1'b0;
    bus.id_src_idx     = '0;
    bus.id_src_used    = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_reg_wr_idx  = '0;
    bus.ex_mem_read_en = 1'b0;
    bus.ex_mc_start    = 1'b0;
    bus.mc_done        = 1'b0;
    bus.redirect_req   = 1'b0;
    bus.mem_busy       = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wr, input logic [4:0] s1,
                          input logic [4:0] s0, input logic [1:0] used);
    bus.id_valid       = 1'b1;
    bus.ex_valid       = 1'b1;
    bus.ex_mem_read_en = 1'b1;
    bus.ex_reg_wr_idx  = wr;
    bus.id_src_idx     = {s1, s0};
    bus.id_src_used    = used;
  endtask

  // Inputs are already driven at the falling edge; check mid-low-phase, then
  // advance the stall model by what this cycle should contribute.
  task automatic cyc(input string tag, input logic [4:0] outs);
    exp_t       e;
    exp_t       g;
    logic [4:0] obs;
    e.tag = tag; e.outs = outs; e.stall = m_stall;
    sb.push_back(e);
    #1;
    g   = sb.pop_front();
    obs = {bus.fe_enable, bus.id_ex_enable, bus.if_id_clear, bus.id_ex_clear, bus.ex_mem_clear};
    n_tests++;
    assert (obs === g.outs) else begin
      n_fail++;
      $error("FAIL %s: outs got %b want %b", g.tag, obs, g.outs);
    end
    n_tests++;
    assert (bus.stall_cycles === g.stall) else begin
      n_fail++;
      $error("FAIL %s: stall_cycles got %0d want %0d", g.tag, bus.stall_cycles, g.stall);
    end
    if (!rst && !outs[4] && m_stall != '1) m_stall = m_stall + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    m_stall = '0;
    cyc("rst_idle", NORM);
    bus.redirect_req = 1'b1;
    set_load(5'd5, 5'd5, 5'd5, 2'b11);
    cyc("rst_events", NORM);
    idle();
    rst = 1'b0;
    cyc("idle", NORM);

    // load-use on src1 = x5: two stall cycles
    set_load(5'd5, 5'd5, 5'd3, 2'b11);
    cyc("lu_c1", LDS);
    bus.ex_valid = 1'b0; bus.ex_mem_read_en = 1'b0;
    cyc("lu_c2", LDS);
    cyc("lu_done", NORM);

    set_load(5'd0, 5'd1, 5'd0, 2'b11);
    cyc("lu_x0", NORM);
    set_load(5'd7, 5'd7, 5'd7, 2'b00);
    cyc("lu_unused", NORM);
    set_load(5'd7, 5'd7, 5'd2, 2'b01);
    cyc("lu_unused_src1", NORM);
    set_load(5'd9, 5'd1, 5'd9, 2'b01);
    bus.id_valid = 1'b0;
    cyc("lu_id_invalid", NORM);
    idle();

    // multi-cycle op, done after four wait cycles
    bus.ex_mc_start = 1'b1;
    cyc("mc_start", NORM);
    bus.ex_mc_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mc_wait", MCW);
    bus.mc_done = 1'b1;
    cyc("mc_done", NORM);
    bus.mc_done = 1'b0;
    cyc("mc_after", NORM);
    bus.ex_mc_start = 1'b1; bus.mc_done = 1'b1;
    cyc("mc_same_cycle", NORM);
    idle();
    cyc("mc_same_after", NORM);

    // redirect with load-use pending during the flush window
    bus.redirect_req = 1'b1;
    set_load(5'd4, 5'd4, 5'd0, 2'b10);
    cyc("rd_c1", RDR);
    bus.redirect_req = 1'b0;
    cyc("rd_suppress1", FLS);
    cyc("rd_suppress2", FLS);
    cyc("rd_lu_after", LDS);
    idle();
    bus.redirect_req = 1'b1;
    cyc("rd_abort_stall", RDR);
    bus.redirect_req = 1'b0;
    cyc("rd_abort_f2", FLS);
    cyc("rd_abort_f3", FLS);
    cyc("rd_abort_end", NORM);

    // redirect arriving mid-flush reloads the window
    bus.redirect_req = 1'b1;
    cyc("rl_c1", RDR);
    bus.redirect_req = 1'b0;
    cyc("rl_c2", FLS);
    bus.redirect_req = 1'b1;
    cyc("rl_reload", RDR);
    bus.redirect_req = 1'b0;
    cyc("rl_f2", FLS);
    cyc("rl_f3", FLS);
    cyc("rl_end", NORM);

    // memory wait freezes an in-progress load stall
    set_load(5'd6, 5'd0, 5'd6, 2'b01);
    cyc("mb_lu", LDS);
    idle();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mb_freeze", BUSY);
    bus.mem_busy = 1'b0;
    cyc("mb_resume", LDS);
    cyc("mb_done", NORM);
    bus.mem_busy = 1'b1; bus.redirect_req = 1'b1;
    cyc("mb_over_redirect", BUSY);
    idle();
    cyc("mb_no_flush", NORM);

    // asynchronous reset in the middle of a multi-cycle wait
    bus.ex_mc_start = 1'b1;
    cyc("rm_start", NORM);
    bus.ex_mc_start = 1'b0;
    cyc("rm_wait1", MCW);
    cyc("rm_wait2", MCW);
    rst = 1'b1;
    m_stall = '0;
    cyc("rm_in_reset", NORM);
    rst = 1'b0;
    cyc("rm_release", NORM);
    cyc("rm_release2", NORM);

    // stall counter saturation
    bus.ex_mc_start = 1'b1;
    cyc("sat_start", NORM);
    bus.ex_mc_start = 1'b0;
    for (int i = 0; i < 260; i++) cyc("sat_wait", MCW);
    bus.mc_done = 1'b1;
    cyc("sat_done", NORM);
    idle();
    cyc("sat_hold", NORM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
